// File: rtl/ram_frame_streamer.sv
// Sequential wrap-around read engine for a 2-cycle-latency no-change frame RAM.
// Streams words over valid/ready with a credit-limited output FIFO.
module ram_frame_streamer #(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    // $clog2(RAM_DEPTH) equals the legacy clogb2(RAM_DEPTH-1)
    parameter int ADDR_W     = $clog2(RAM_DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic                 ram_regcea,
    output logic                 ram_rsta,
    input  logic [RAM_WIDTH-1:0] ram_douta,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    localparam logic [ADDR_W:0]   DEPTH_LEN  = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [SUM_W-1:0]  CREDIT_MAX = SUM_W'(FIFO_DEPTH);

    logic [1:0]           state;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W:0]      rd_left;
    logic                 pipe_v1, pipe_v2;
    logic                 pipe_l1, pipe_l2;
    logic [RAM_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                 fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_count;

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 issue_last;
    logic [SUM_W-1:0]     credit_sum;
    logic [ADDR_W-1:0]    start_addr;
    logic [ADDR_W:0]      start_len;

    assign ram_wea    = 1'b0;
    assign ram_regcea = 1'b1;
    assign ram_rsta   = rsta;
    assign ram_addr   = addr_q;
    assign ram_ena    = issue;

    always_comb begin
        busy       = (state == ST_READ) || (state == ST_DRAIN);
        done       = (state == ST_DONE);
        accept     = start && !busy;
        m_valid    = (fifo_count != '0);
        m_data     = fifo_data[rd_ptr];
        m_last     = m_valid && fifo_last[rd_ptr];
        pop        = m_valid && m_ready;
        push       = pipe_v2;
        // Words already buffered plus reads still in the RAM pipeline, net of this cycle's pop
        credit_sum = SUM_W'(fifo_count) + SUM_W'(pipe_v1) + SUM_W'(pipe_v2) - SUM_W'(pop);
        issue      = (state == ST_READ) && (credit_sum < CREDIT_MAX);
        issue_last = issue && (rd_left == (ADDR_W+1)'(1));
        start_addr = ({1'b0, base_addr} >= DEPTH_LEN) ? (base_addr - DEPTH_ADDR) : base_addr;
        start_len  = (length > DEPTH_LEN) ? DEPTH_LEN : length;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            rd_left    <= '0;
            pipe_v1    <= 1'b0;
            pipe_v2    <= 1'b0;
            pipe_l1    <= 1'b0;
            pipe_l2    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            pipe_v1 <= issue;
            pipe_l1 <= issue_last;
            pipe_v2 <= pipe_v1;
            pipe_l2 <= pipe_l1;

            if (push) begin
                fifo_data[wr_ptr] <= ram_douta;
                fifo_last[wr_ptr] <= pipe_l2;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE also accepts start so back-to-back commands lose no cycle
                    if (accept) begin
                        addr_q  <= start_addr;
                        rd_left <= start_len;
                        state   <= (length == '0) ? ST_DONE : ST_READ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                        rd_left <= rd_left - (ADDR_W+1)'(1);
                        if (issue_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_last) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_frame_streamer.sv
// Randomized self-checking bench for ram_frame_streamer against a queue-based
// model of the expected address and word streams and command timing.
module tb_ram_frame_streamer;
    localparam int RAM_WIDTH  = 18;
    localparam int RAM_DEPTH  = 1024;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;

    logic                 clka = 1'b0;
    logic                 rsta;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [ADDR_W:0]      length;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    ram_addr;
    logic                 ram_ena;
    logic                 ram_wea;
    logic                 ram_regcea;
    logic                 ram_rsta;
    logic [RAM_WIDTH-1:0] ram_douta = '0;
    logic [RAM_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    ram_frame_streamer #(
        .RAM_WIDTH (RAM_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clka      (clka),
        .rsta      (rsta),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_regcea(ram_regcea),
        .ram_rsta  (ram_rsta),
        .ram_douta (ram_douta),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clka = ~clka;

    // Frame RAM: address latch then output register, two cycles of latency
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_lat = '0;
    always @(posedge clka) begin
        if (ram_ena && !ram_wea) ram_lat <= mem[ram_addr];
        if (ram_rsta) ram_douta <= '0;
        else if (ram_regcea) ram_douta <= ram_lat;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int rel;
    int ready_mode = 0;
    int pat_idx = 0;
    int issued = 0;
    int popped = 0;
    int first_rel, last_rel, done_rel;
    int total_done = 0;
    int n_done_cmds = 0;
    bit done_seen = 0;
    bit cmd_active = 0;
    bit exp_busy1 = 0;
    bit prev_stall = 0;
    logic [RAM_WIDTH-1:0] prev_data;
    logic                 prev_last;
    logic [RAM_WIDTH:0]   e;
    logic [RAM_WIDTH:0]   exp_q[$];
    int                   exp_addr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clka) cyc <= cyc + 1;

    always @(posedge clka) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (pat_idx == 0) || (pat_idx == 3);
                pat_idx = (pat_idx + 1) % 4;
            end
            default: m_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    always @(negedge clka) begin
        rel = cyc - t0 + 1;
        if (ram_ena) begin
            issued++;
            if (exp_addr_q.size() == 0) check("extra_read", 32'd1, 32'd0);
            else check("ram_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
        end
        if (prev_stall) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
            popped++;
            if (first_rel < 0) first_rel = rel;
            if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("m_data", m_data, e[RAM_WIDTH-1:0]);
                check("m_last", m_last, e[RAM_WIDTH]);
            end
            if (m_last) last_rel = rel;
        end
        check("credit", (issued - popped) <= FIFO_DEPTH, 1);
        if (cmd_active && rel == 1) check("busy_c1", busy, exp_busy1);
        if (done) begin
            total_done++;
            done_seen = 1;
            done_rel  = rel;
            check("busy_at_done", busy, 0);
        end
    end

    task automatic start_cmd(input int base, input int len);
        int b, n, a;
        b = (base >= RAM_DEPTH) ? base - RAM_DEPTH : base;
        n = (len > RAM_DEPTH) ? RAM_DEPTH : len;
        for (int k = 0; k < n; k++) begin
            a = (b + k) % RAM_DEPTH;
            exp_addr_q.push_back(a);
            exp_q.push_back({(k == n - 1), mem[a]});
        end
        exp_busy1 = (n != 0);
        first_rel = -1;
        last_rel  = -1;
        done_rel  = -1;
        done_seen = 0;
        issued    = 0;
        popped    = 0;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        length    = (ADDR_W+1)'(len);
        @(posedge clka);
        #1;
        start      = 1'b0;
        t0         = cyc;
        cmd_active = 1;
    endtask

    task automatic run_cmd(input int base, input int len, input int mode, input bit repulse);
        int n, budget;
        bit timed_out;
        ready_mode = mode;
        n = (len > RAM_DEPTH) ? RAM_DEPTH : len;
        budget = 4 * n + 50;
        start_cmd(base, len);
        timed_out = 1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clka);
            #1;
            if (repulse && k == 1) begin
                start     = 1'b1;
                base_addr = ADDR_W'(500);
                length    = (ADDR_W+1)'(3);
            end else begin
                start = 1'b0;
            end
            if (done_seen) begin
                timed_out = 0;
                break;
            end
        end
        start = 1'b0;
        check("timeout", timed_out, 0);
        check("words_left", exp_q.size(), 0);
        check("reads_left", exp_addr_q.size(), 0);
        if (mode == 0) begin
            if (n > 0) begin
                check("first_word_cycle", first_rel, 4);
                check("last_word_cycle", last_rel, 3 + n);
                check("done_cycle", done_rel, 4 + n);
            end else begin
                check("done_cycle", done_rel, 1);
            end
        end
        n_done_cmds++;
    endtask

    task automatic abort_test();
        int snap;
        bit reached;
        ready_mode = 0;
        start_cmd(200, 10);
        reached = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clka);
            #1;
            if (popped >= 3) begin
                reached = 1;
                break;
            end
        end
        check("abort_reach3", reached, 1);
        rsta = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        cmd_active = 0;
        @(posedge clka);
        #1;
        check("abort_m_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rsta       = 1'b0;
        issued     = 0;
        popped     = 0;
        prev_stall = 0;
        snap       = total_done;
        repeat (8) @(negedge clka);
        #1;
        check("abort_no_done", total_done, snap);
    endtask

    initial begin
        int base, len, mode, r;
        rsta      = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b1;
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = RAM_WIDTH'(i + 'h100);
        repeat (3) @(posedge clka);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_ram_ena", ram_ena, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_m_data", m_data, 0);
        rsta = 1'b0;
        @(negedge clka);
        #1;

        run_cmd(10, 5, 0, 0);
        run_cmd(1022, 4, 0, 0);
        run_cmd(300, 16, 1, 0);
        run_cmd(77, 0, 0, 0);
        run_cmd(0, 8, 0, 1);
        abort_test();
        run_cmd(600, 6, 0, 0);

        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = RAM_WIDTH'($urandom);
        for (int c = 0; c < 30; c++) begin
            base = $urandom_range(0, RAM_DEPTH - 1);
            mode = $urandom_range(0, 2);
            r    = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(RAM_DEPTH + 1, 2 * RAM_DEPTH - 1);
            else len = $urandom_range(1, 40);
            run_cmd(base, len, mode, 0);
        end
        run_cmd(900, 1500, 2, 0);
        run_cmd(5, 2047, 0, 0);
        run_cmd(1023, 1, 0, 0);

        check("done_total", total_done, n_done_cmds);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
